// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encodings, bus bit meanings and the
// default target address used by both the target and the controller.
package i2c_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_WR_DATA  = 3'd3,
        S_WR_ACK   = 3'd4,
        S_RD_DATA  = 3'd5,
        S_RD_ACK   = 3'd6,
        S_IGNORE   = 3'd7
    } i2c_state_t;

    localparam logic       I2C_ACK          = 1'b0;
    localparam logic       I2C_NACK         = 1'b1;
    localparam logic       I2C_READ         = 1'b1;
    localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h50;

    // Open-drain helper: the pull-down is enabled exactly when the bit is 0.
    function automatic logic drive_low(input logic bit_val);
        return ~bit_val;
    endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// Bus-side observer: synchronizes SCL/SDA, derives SCL edges and START/STOP.
// All event outputs are registered, so they appear SYNC_STAGES+1 CLK after
// the pin change. sda is the synchronized SDA aligned with the event pulses.
module i2c_bus_monitor #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic NRST,
    input  logic scl_pin,
    input  logic sda_pin,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda
);

    logic [SYNC_STAGES-1:0] scl_ff;
    logic [SYNC_STAGES-1:0] sda_ff;
    logic                   scl_hist;
    logic                   sda_hist;
    logic                   scl_s;
    logic                   sda_s;

    assign scl_s = scl_ff[SYNC_STAGES-1];
    assign sda_s = sda_ff[SYNC_STAGES-1];

    // Synchronizer chains plus one history flop; reset to the idle-bus level.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            scl_ff   <= '1;
            sda_ff   <= '1;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_ff   <= {scl_ff[SYNC_STAGES-2:0], scl_pin};
            sda_ff   <= {sda_ff[SYNC_STAGES-2:0], sda_pin};
            scl_hist <= scl_s;
            sda_hist <= sda_s;
        end
    end

    // Edge and condition detection; requiring SCL high in both samples keeps
    // an SDA change coincident with an SCL edge from counting as START/STOP.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start    <= 1'b0;
            stop     <= 1'b0;
            sda      <= 1'b1;
        end else begin
            scl_rise <= scl_s & ~scl_hist;
            scl_fall <= ~scl_s & scl_hist;
            start    <= scl_s & scl_hist & sda_hist & ~sda_s;
            stop     <= scl_s & scl_hist & ~sda_hist & sda_s;
            sda      <= sda_s;
        end
    end

endmodule

// File: rtl/i2c_target.sv
// I2C target for one 7-bit address: write bytes go out on ODATA/ODRDY, read
// bytes are requested with OREQ and taken from IDATA/IDRDY. No stretching.
//
// User handshake: ODRDY is a one-CLK valid pulse with ODATA stable from that
// cycle until the next ODRDY (no ready, every byte is ACKed). OREQ is a
// one-CLK request; IDATA is consumed at the next SCL fall, where IDRDY acts
// as valid: IDRDY=0 sends 8'hFF with the bus released.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = I2C_DEFAULT_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       NRST,
    input  logic       I2C_SCL,
    inout  wire        I2C_SDA,
    input  logic [7:0] IDATA,
    input  logic       IDRDY,
    output logic [7:0] ODATA,
    output logic       ODRDY,
    output logic       OREQ,
    output logic       ORW,
    output logic       BUSY,
    output logic       OSTOP,
    output logic [2:0] DBG_STATE,
    output logic [2:0] DBG_BITCNT
);

    logic       scl_rise, scl_fall, start, stop, sda;
    i2c_state_t state_q, state_n;
    logic [2:0] bit_cnt_q, bit_cnt_n;
    logic [7:0] shreg_q, shreg_n;
    logic       sda_oe_q, sda_oe_n;
    logic       ack_phase_q, ack_phase_n;
    logic [7:0] odata_q, odata_n;
    logic       orw_q, orw_n, busy_q, busy_n;
    logic       odrdy_q, odrdy_n, oreq_q, oreq_n, ostop_q, ostop_n;
    logic [7:0] rx_byte, tx_byte;

    i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_mon (
        .CLK      (CLK),
        .NRST     (NRST),
        .scl_pin  (I2C_SCL),
        .sda_pin  (I2C_SDA),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop),
        .sda      (sda)
    );

    assign rx_byte = {shreg_q[6:0], sda};
    assign tx_byte = IDRDY ? IDATA : 8'hFF;

    // State and datapath registers; reset releases SDA immediately.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            shreg_q     <= 8'h00;
            sda_oe_q    <= 1'b0;
            ack_phase_q <= 1'b0;
            odata_q     <= 8'h00;
            orw_q       <= 1'b0;
            busy_q      <= 1'b0;
            odrdy_q     <= 1'b0;
            oreq_q      <= 1'b0;
            ostop_q     <= 1'b0;
        end else begin
            state_q     <= state_n;
            bit_cnt_q   <= bit_cnt_n;
            shreg_q     <= shreg_n;
            sda_oe_q    <= sda_oe_n;
            ack_phase_q <= ack_phase_n;
            odata_q     <= odata_n;
            orw_q       <= orw_n;
            busy_q      <= busy_n;
            odrdy_q     <= odrdy_n;
            oreq_q      <= oreq_n;
            ostop_q     <= ostop_n;
        end
    end

    // Next-state and output logic; STOP and START override every state.
    // ack_phase marks the 9th clock: SDA held for an ACK, or controller ACK seen.
    always_comb begin
        state_n     = state_q;
        bit_cnt_n   = bit_cnt_q;
        shreg_n     = shreg_q;
        sda_oe_n    = sda_oe_q;
        ack_phase_n = ack_phase_q;
        odata_n     = odata_q;
        orw_n       = orw_q;
        busy_n      = busy_q;
        odrdy_n     = 1'b0;
        oreq_n      = 1'b0;
        ostop_n     = 1'b0;
        if (stop) begin
            state_n     = S_IDLE;
            bit_cnt_n   = 3'd0;
            sda_oe_n    = 1'b0;
            ack_phase_n = 1'b0;
            busy_n      = 1'b0;
            ostop_n     = busy_q;
        end else if (start) begin
            state_n     = S_ADDR;
            bit_cnt_n   = 3'd0;
            sda_oe_n    = 1'b0;
            ack_phase_n = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_IGNORE: begin
                end
                S_ADDR: begin
                    if (scl_rise) begin
                        shreg_n   = rx_byte;
                        bit_cnt_n = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (rx_byte[7:1] == TARGET_ADDR) begin
                                orw_n   = rx_byte[0];
                                busy_n  = 1'b1;
                                state_n = S_ADDR_ACK;
                            end else begin
                                busy_n  = 1'b0;
                                state_n = S_IGNORE;
                            end
                        end
                    end
                end
                S_ADDR_ACK, S_WR_ACK: begin
                    if (scl_rise && ack_phase_q && state_q == S_ADDR_ACK && orw_q == I2C_READ)
                        oreq_n = 1'b1;
                    if (scl_fall) begin
                        if (!ack_phase_q) begin
                            sda_oe_n    = drive_low(I2C_ACK);
                            ack_phase_n = 1'b1;
                        end else begin
                            ack_phase_n = 1'b0;
                            bit_cnt_n   = 3'd0;
                            if (state_q == S_ADDR_ACK && orw_q == I2C_READ) begin
                                state_n  = S_RD_DATA;
                                shreg_n  = tx_byte;
                                sda_oe_n = drive_low(tx_byte[7]);
                            end else begin
                                state_n  = S_WR_DATA;
                                sda_oe_n = 1'b0;
                            end
                        end
                    end
                end
                S_WR_DATA: begin
                    if (scl_rise) begin
                        shreg_n   = rx_byte;
                        bit_cnt_n = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            odata_n = rx_byte;
                            odrdy_n = 1'b1;
                            state_n = S_WR_ACK;
                        end
                    end
                end
                S_RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            sda_oe_n  = 1'b0;
                            bit_cnt_n = 3'd0;
                            state_n   = S_RD_ACK;
                        end else begin
                            shreg_n   = {shreg_q[6:0], 1'b1};
                            bit_cnt_n = bit_cnt_q + 3'd1;
                            sda_oe_n  = drive_low(shreg_q[6]);
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda == I2C_NACK) begin
                            state_n = S_IGNORE;
                        end else begin
                            oreq_n      = 1'b1;
                            ack_phase_n = 1'b1;
                        end
                    end else if (scl_fall && ack_phase_q) begin
                        ack_phase_n = 1'b0;
                        bit_cnt_n   = 3'd0;
                        state_n     = S_RD_DATA;
                        shreg_n     = tx_byte;
                        sda_oe_n    = drive_low(tx_byte[7]);
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign I2C_SDA    = sda_oe_q ? 1'b0 : 1'bz;
    assign ODATA      = odata_q;
    assign ODRDY      = odrdy_q;
    assign OREQ       = oreq_q;
    assign ORW        = orw_q;
    assign BUSY       = busy_q;
    assign OSTOP      = ostop_q;
    assign DBG_STATE  = state_q;
    assign DBG_BITCNT = bit_cnt_q;

endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (responder) for a single 7-bit address, the bus-side counterpart of the team's `i2c_controller`. It oversamples SCL/SDA on the system clock, detects START/STOP, and matches the address. Write bytes go to user logic as `ODATA`/`ODRDY`; read bytes are pulled from user logic via `OREQ`/`IDATA`/`IDRDY`. Standard I2C framing, MSB first, no clock stretching, no general call.

## Interface
- `TARGET_ADDR`, 7'h50, own 7-bit address.
- `SYNC_STAGES`, 2, flip-flops in each SCL/SDA input synchronizer (≥2).
- `CLK`  in  1  system clock; must be ≥16× the SCL frequency.
- `NRST`  in  1  reset, asynchronous, active-low.
- `I2C_SCL`  in  1  bus clock (input only).
- `I2C_SDA`  inout  1  open-drain; driven 1'b0 or 1'bz, never 1'b1.
- `IDATA`  in  8  next byte to send in a read.
- `IDRDY`  in  1  `IDATA` valid; sampled at byte load.
- `ODATA`  out  8  last written byte; holds until the next byte.
- `ODRDY`  out  1  one-cycle pulse, `ODATA` updated.
- `OREQ`  out  1  one-cycle pulse, user must present next read byte.
- `ORW`  out  1  direction of the current addressed transfer (1 = read).
- `BUSY`  out  1  high from address match until STOP, or until a repeated START with mismatch.
- `OSTOP`  out  1  one-cycle pulse on any STOP seen while `BUSY`.

## Operation
- Input path:
  - SCL and SDA each go through `SYNC_STAGES` flops plus one history flop.
  - `scl_rise`/`scl_fall` come from synchronized SCL.
  - START = synchronized SDA 1→0 while SCL is high in both current and previous sample.
  - STOP = synchronized SDA 0→1 under the same condition.
  - An SDA change in the same cycle as an SCL edge is neither START nor STOP.
- States:
  - S_IDLE: wait for START.
  - S_ADDR: shift 8 bits on `scl_rise` (addr[6:0], R/W).
  - S_ADDR_ACK: drive the address ACK.
  - S_WR_DATA: shift 8 bits on `scl_rise`.
  - S_WR_ACK: drive the write ACK.
  - S_RD_DATA: shift bits out on `scl_fall`.
  - S_RD_ACK: sample the controller's ACK/NACK.
  - S_IGNORE: SDA released; wait for START/STOP.
- START in any state → S_ADDR, bit counter = 0, SDA released. This covers repeated START.
- STOP in any state → S_IDLE, SDA released, `BUSY`=0, `OSTOP` pulse if `BUSY` was 1.
- S_ADDR, after the 8th `scl_rise`:
  - Match: `ORW` = R/W bit, `BUSY`=1, go to S_ADDR_ACK.
  - Mismatch: go to S_IGNORE.
- S_ADDR_ACK / S_WR_ACK:
  - At the `scl_fall` following the 8th bit, drive SDA=0.
  - At the next `scl_fall` (end of the 9th clock), release SDA and go to S_WR_DATA or S_RD_DATA. From S_WR_ACK the next state is always S_WR_DATA.
- Write path:
  - On the 8th data `scl_rise`, `ODATA` ← shifted byte and `ODRDY` pulses in the next cycle.
  - Every byte is ACKed; there is no back-pressure.
- Read path:
  - `OREQ` pulses on the 9th `scl_rise` of the address ACK (read match) and of each controller ACK.
  - At the following `scl_fall`, load the shift register with `IDATA` if `IDRDY`=1, else 8'hFF (underrun, bus released).
  - Drive the MSB at that edge; SDA=0 for bit 0, released for bit 1. Later bits shift on each `scl_fall`.
  - After 8 bits, release SDA at the next `scl_fall` and go to S_RD_ACK.
- S_RD_ACK, on the 9th `scl_rise`:
  - SDA=0 (ACK): `OREQ` pulse, continue in S_RD_DATA.
  - SDA=1 (NACK): go to S_IGNORE.
- Bit counter: 3 bits, wraps 7→0 at byte end. The shift register is 8 bits.

## Timing
- Reset values:
  - SDA released.
  - `ODATA`=8'h00.
  - `ODRDY`, `OREQ`, `ORW`, `BUSY`, `OSTOP` all 0.
  - State S_IDLE.
- NRST asserted mid-transfer releases SDA immediately (asynchronous).
- Pin-to-detection latency: `SYNC_STAGES`+1 CLK. SDA output changes 1 CLK after detection, i.e. `SYNC_STAGES`+2 CLK after the SCL pin falls (4 CLK at default).
- `ODRDY`: `SYNC_STAGES`+2 CLK after the 8th data SCL rise at the pin.
- `IDATA`/`IDRDY` must be valid by the CLK in which the 9th-clock `scl_fall` is detected, which is ≥ SCL high time after `OREQ`.
- All output pulses are exactly one CLK wide.

## Structure
- Shared package `i2c_pkg`:
  - State encodings.
  - `I2C_ACK`=1'b0, `I2C_NACK`=1'b1, `I2C_READ`=1'b1.
  - Default address constant.
- Sub-module `i2c_bus_monitor`: synchronizers, edge detection, START/STOP detection.
  - Outputs: `scl_rise`, `scl_fall`, `start`, `stop`, synchronized `sda`.
  - To be reused later by the controller for bus-busy and arbitration checks.

## Test plan
- Write 0xA0 (addr 0x50, W), data 0x3C, STOP → ACK on both 9th clocks, `ODATA`=0x3C with one `ODRDY`, `OSTOP` pulse, `BUSY` back to 0.
- Read 0xA1, `IDATA`=0x96/`IDRDY`=1, controller ACK then NACK with second byte 0x5A → SDA shows 1001_0110 then 0101_1010, two `OREQ` pulses, S_IGNORE until STOP.
- Address 0x51 (W) → SDA never driven, no `ODRDY`, `BUSY` stays 0; a following write to 0x50 after repeated START is ACKed.
- Write 0xA0, data 0x11, repeated START, 0xA1, read with `IDRDY`=0 → 0x11 received, `ORW` goes to 1, 8'hFF sent (SDA released).
- NRST pulsed while driving address ACK low → SDA goes Z asynchronously, all outputs 0, next transaction works.
- SDA toggled while SCL high mid-byte (glitch START) → frame restarts at S_ADDR, bit counter 0, no spurious `ODRDY`.
